output_arb: RTL and testbench
=============================

Name: output_arb

Overview:
- AXI write-side counterpart to the accelerator's read arbiter.
- Shares one AXI write master port among Np output requesters using round-robin arbitration.
- Each grant issues exactly one fixed-length 64-bit burst and waits for the write response.
- Sits between the accelerator's output/store units and the memory controller; the AR/R channels are owned elsewhere.

Parameters:
- Np, 1: number of requesters.
- Ntfr, 64: beats per burst (power of two, 2..256); Nb = log2(Ntfr*8) address bits per burst.
- debug, 0: when 1, the err flag also latches bvalid seen outside Resp.

Ports:
- aclk  in  1  clock
- arst_n  in  1  reset, synchronous, active-low
- wreq[Np]  in  1  burst request; hold high until wdone
- wadr[Np]  in  24  byte offset of burst; bits [Nb-1:0] ignored
- wdata[Np]  in  64  beat data; the next beat is presented while wack is low
- wack[Np]  out  1  beat consumed (combinational)
- wdone[Np]  out  1  one-cycle pulse: burst response received
- baseadr  in  32  region base added to the address
- err  out  1  sticky: any bresp != OKAY
- awaddr  out  40  burst address
- awlen  out  8  constant Ntfr-1
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- wr_data  out  64  W data
- wvalid  out  1  W valid
- wlast  out  1  last beat
- wready  in  1  W ready
- bvalid  in  1  B valid
- bresp  in  2  B response
- bready  out  1  B ready

Behaviour:
- Reset (arst_n low at a clock edge): state Idle; awvalid, wvalid, bready, wdone, err = 0; beat count 0; ch 0; rr pointer = Np-1, so requester 0 wins first.
- Reset mid-burst abandons the burst with no wdone. Outputs reach reset values at the same edge.
- awaddr = zero-extend({wadr[ch][23:Nb], Nb zeros}) + zero-extend(baseadr), 40-bit unsigned, no overflow check. It is registered at grant.
- States: Idle, Addr, Data, Resp, Post.
  - Idle: if any wreq is high, grant the first set wreq searching from (ptr+1) mod Np upward with wrap. Latch ch and awaddr; awvalid <= 1; go to Addr. Otherwise stay.
  - Addr: hold awvalid and awaddr. On awready: awvalid <= 0, wvalid <= 1, go to Data. awvalid never drops without handshake.
  - Data: wr_data = wdata[ch] combinational. wack[ch] = wvalid & wready; other wack are 0. Beat count increments on each handshake. wlast = wvalid & (count == Ntfr-1). On the handshake with wlast: wvalid <= 0, bready <= 1, go to Resp. wvalid stays high through wready stalls.
  - Resp: on bvalid: bready <= 0; err <= err | (bresp != 0); ptr <= ch; wdone[ch] <= 1; go to Post.
  - Post: wdone pulse is high this cycle only; go to Idle.
- Requester contract: deassert wreq at the edge where wdone is sampled high. Idle therefore never regrants the same burst.
- Latency, with awready and wready always high and B returned one cycle after the last W:
  - awvalid: 1 cycle after wreq is sampled in Idle.
  - First W beat: 1 cycle after the AW handshake.
  - Ntfr beats in Ntfr cycles.
- No overlap: AW for burst n+1 is not issued before B for burst n.
- bvalid outside Resp is ignored (bready = 0). With debug = 1 it sets err.
- The wreq of non-granted requesters is ignored until Idle. Changes to wadr[ch] after grant have no effect.
- Np = 1: arbitration degenerates to a single requester; behaviour is otherwise identical.

Decomposition:
- Shared package acc_axi_pkg:
  - state enum {Idle, Addr, Data, Resp, Post}
  - AXI resp constants OKAY = 2'b00, SLVERR = 2'b10
  - function clog2-based Nb(Ntfr)
- Sub-module rr_arbiter #(Np):
  - inputs: req[Np], ptr
  - output: grant index and any-request flag
  - combinational wrap-around priority search
  - reusable by the read side later

Test Plan:
- Np=2, baseadr=32'h1000_0000, wreq[0] with wadr=24'h000200, all ready high -> awaddr=40'h00_1000_0200, awlen=63, 64 wack[0] pulses, wlast on beat 64 only, wdone[0] a single pulse, err=0.
- wadr=24'h0001FF -> awaddr=40'h00_1000_0000 (low 9 bits dropped).
- wreq[0] and wreq[1] both held high from reset, each re-requesting after wdone -> grant order 0,1,0,1 with strict alternation.
- wready low on alternate cycles -> 64 wack exactly on handshakes, data order preserved, wvalid never drops mid-burst, total 127 cycles in Data.
- Hold awready low for 5 cycles -> awvalid stays high, awaddr is stable, and no W beat occurs before the AW handshake.
- bresp=2'b10 -> err=1 and stays 1 across later OKAY bursts, wdone still pulses; arst_n low at beat 10 of the next burst -> all outputs 0 at that edge, no wdone, and a re-request replays a full 64-beat burst.

Source files
------------

// File: rtl/acc_axi_pkg.sv
// Shared AXI write-side types and helpers for the accelerator output path.
package acc_axi_pkg;

    typedef enum logic [2:0] {Idle, Addr, Data, Resp, Post} state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Address bits covered by one burst of ntfr 64-bit beats.
    function automatic int unsigned nb_bits(input int unsigned ntfr);
        return $clog2(ntfr * 8);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned Np = 1,
    parameter int unsigned Pw = (Np > 1) ? $clog2(Np) : 1
) (
    input  logic [Np-1:0] req,
    input  logic [Pw-1:0] ptr,
    output logic [Pw-1:0] grant,
    output logic          any
);

    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int unsigned i = 1; i <= Np; i++) begin
            if (!any && req[(32'(ptr) + i) % Np]) begin
                any   = 1'b1;
                grant = Pw'((32'(ptr) + i) % Np);
            end
        end
    end

endmodule

// File: rtl/output_arb.sv
// Round-robin sharing of one AXI write master among Np output requesters;
// one fixed-length burst per grant, next grant only after the write response.
module output_arb
    import acc_axi_pkg::*;
#(
    parameter int unsigned Np    = 1,
    parameter int unsigned Ntfr  = 64,
    parameter bit          debug = 1'b0
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic [Np-1:0]    wreq,
    input  logic [Np*24-1:0] wadr,
    input  logic [Np*64-1:0] wdata,
    output logic [Np-1:0]    wack,
    output logic [Np-1:0]    wdone,
    input  logic [31:0]      baseadr,
    output logic             err,
    output logic [39:0]      awaddr,
    output logic [7:0]       awlen,
    output logic             awvalid,
    input  logic             awready,
    output logic [63:0]      wr_data,
    output logic             wvalid,
    output logic             wlast,
    input  logic             wready,
    input  logic             bvalid,
    input  logic [1:0]       bresp,
    output logic             bready
);

    localparam int unsigned Nb = nb_bits(Ntfr);
    localparam int unsigned Cw = $clog2(Ntfr);
    localparam int unsigned Pw = (Np > 1) ? $clog2(Np) : 1;

    state_t        state, state_nxt;
    logic [Pw-1:0] ch, ptr, gnt;
    logic          any_req;
    logic [Cw-1:0] cnt;
    logic [23:0]   sel_adr;
    logic [39:0]   gnt_addr;
    logic          w_hs;

    rr_arbiter #(.Np(Np), .Pw(Pw)) u_rr (
        .req   (wreq),
        .ptr   (ptr),
        .grant (gnt),
        .any   (any_req)
    );

    always_comb begin
        sel_adr         = wadr[gnt*24 +: 24];
        sel_adr[Nb-1:0] = '0;
        gnt_addr        = 40'(sel_adr) + 40'(baseadr);
    end

    // Channel valids and the done pulse are decodes of the registered state,
    // so they switch on the same edges as explicitly registered flags would.
    assign awvalid = (state == Addr);
    assign wvalid  = (state == Data);
    assign bready  = (state == Resp);
    assign awlen   = 8'(Ntfr - 1);
    assign wr_data = wdata[ch*64 +: 64];
    assign w_hs    = wvalid & wready;
    assign wlast   = wvalid & (cnt == Cw'(Ntfr - 1));

    always_comb begin
        wack  = '0;
        wdone = '0;
        for (int unsigned i = 0; i < Np; i++) begin
            wack[i]  = w_hs && (32'(ch) == i);
            wdone[i] = (state == Post) && (32'(ch) == i);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            Idle:    if (any_req)       state_nxt = Addr;
            Addr:    if (awready)       state_nxt = Data;
            Data:    if (w_hs && wlast) state_nxt = Resp;
            Resp:    if (bvalid)        state_nxt = Post;
            Post:                       state_nxt = Idle;
            default:                    state_nxt = Idle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state  <= Idle;
            ch     <= '0;
            ptr    <= Pw'(Np - 1);
            cnt    <= '0;
            awaddr <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == Idle && any_req) begin
                ch     <= gnt;
                awaddr <= gnt_addr;
            end
            // Power-of-two burst length: the counter wraps to 0 on the last beat.
            if (w_hs)
                cnt <= cnt + 1'b1;
            if (state == Resp && bvalid) begin
                ptr <= ch;
                if (bresp != OKAY)
                    err <= 1'b1;
            end
            if (debug && bvalid && state != Resp)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_output_arb.sv
// Randomised bench for output_arb with a transaction-level model and directed literal checks.
module tb_output_arb;

    localparam int NP = 2;
    localparam int NT = 64;
    localparam int NB = $clog2(NT * 8);

    logic             aclk = 1'b0;
    logic             arst_n;
    logic [NP-1:0]    wreq;
    logic [NP*24-1:0] wadr;
    logic [NP*64-1:0] wdata;
    logic [NP-1:0]    wack, wdone;
    logic [31:0]      baseadr;
    logic             err;
    logic [39:0]      awaddr;
    logic [7:0]       awlen;
    logic             awvalid, awready;
    logic [63:0]      wr_data;
    logic             wvalid, wlast, wready, bvalid;
    logic [1:0]       bresp;
    logic             bready;

    output_arb #(.Np(NP), .Ntfr(NT), .debug(1'b0)) dut (
        .aclk(aclk), .arst_n(arst_n), .wreq(wreq), .wadr(wadr), .wdata(wdata),
        .wack(wack), .wdone(wdone), .baseadr(baseadr), .err(err),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wr_data(wr_data), .wvalid(wvalid), .wlast(wlast), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    // requester side and stimulus knobs
    logic [23:0] radr [NP];
    int unsigned seq  [NP];
    int unsigned beat [NP];
    int          left [NP];
    int  p_req = 100, p_aw = 100, p_w = 100, p_b = 100, aw_left = 0, alt_cnt = 0;
    bit  alt = 0, noise = 0, rand_resp = 0, scramble = 0;
    logic [1:0] fixed_resp = 2'b00;

    // transaction-level model of the arbiter
    bit          aw_pend = 0, w_act = 0, b_pend = 0, done_due = 0, m_err = 0;
    int unsigned m_ch = 0, m_last = NP - 1, m_beats = 0;
    logic [39:0] m_addr = '0;
    int unsigned glog [$];

    // observed tallies for the directed expectations
    int cyc = 0, dut_done = 0, n_wlast = 0, data_cyc = 0, aw_cyc = 0, first_aw = -1, first_w = -1;
    int n_wack [NP];
    int n_done [NP];
    int req_cyc [NP];
    logic [NP-1:0] prev_req = '0;
    logic [39:0] first_addr = '0;

    function automatic logic [63:0] beat_data(input int unsigned r, input int unsigned s, input int unsigned b);
        return {8'(r), 24'(s), 32'(b)} ^ 64'h5A5A_0F0F_3C3C_9696;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            if (wreq[i] && wdone[i]) wreq[i] = 1'b0;
            else if (!wreq[i] && left[i] > 0 && $urandom_range(99) < p_req) begin
                wreq[i] = 1'b1;
                left[i]--;
                seq[i]++;
                beat[i] = 0;
            end
            if (scramble) radr[i] = 24'($urandom);
            wadr[i*24 +: 24]  = radr[i];
            wdata[i*64 +: 64] = beat_data(i, seq[i], beat[i]);
        end
        if (scramble) baseadr = $urandom;
        if (awvalid && aw_left > 0) begin
            awready = 1'b0;
            aw_left--;
        end else awready = ($urandom_range(99) < p_aw);
        if (alt) begin
            if (wvalid) begin
                wready = (alt_cnt % 2 == 0);
                alt_cnt++;
            end else begin
                wready  = 1'b1;
                alt_cnt = 0;
            end
        end else wready = ($urandom_range(99) < p_w);
        if (bready) bvalid = ($urandom_range(99) < p_b);
        else        bvalid = noise && ($urandom_range(3) == 0);
        if (rand_resp) bresp = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
        else           bresp = fixed_resp;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge aclk);
            drive();
        end
    endtask

    task automatic clr_stats();
        n_wlast = 0; data_cyc = 0; aw_cyc = 0; first_aw = -1; first_w = -1;
        glog.delete();
        for (int i = 0; i < NP; i++) begin
            n_wack[i] = 0; n_done[i] = 0; req_cyc[i] = 0;
        end
    endtask

    task automatic wait_done(input int n, input int budget);
        int start, k;
        start = dut_done;
        k = 0;
        while (dut_done - start < n && k < budget) begin
            cycles(1);
            k++;
        end
        chk("bursts completed within budget", 64'(dut_done - start), 64'(n));
        cycles(2);
    endtask

    // Compare process: checks every output each cycle, then advances the model
    // by whatever handshakes the next rising edge will perform.
    task automatic step();
        logic [NP-1:0] exp_ack, exp_done;
        cyc++;
        exp_ack  = '0;
        exp_done = '0;
        if (w_act && wready) exp_ack[m_ch] = 1'b1;
        if (done_due)        exp_done[m_ch] = 1'b1;
        chk("awvalid", 64'(awvalid), 64'(aw_pend));
        if (aw_pend) chk("awaddr", 64'(awaddr), 64'(m_addr));
        chk("awlen", 64'(awlen), 64'(NT - 1));
        chk("wvalid", 64'(wvalid), 64'(w_act));
        chk("wlast", 64'(wlast), 64'(w_act && m_beats == NT - 1));
        chk("wack", 64'(wack), 64'(exp_ack));
        if (w_act) chk("wr_data", wr_data, beat_data(m_ch, seq[m_ch], m_beats));
        chk("bready", 64'(bready), 64'(b_pend));
        chk("wdone", 64'(wdone), 64'(exp_done));
        chk("err", 64'(err), 64'(m_err));

        for (int i = 0; i < NP; i++) begin
            if (wreq[i] && !prev_req[i]) req_cyc[i] = cyc;
            prev_req[i] = wreq[i];
            if (wack[i])  n_wack[i]++;
            if (wdone[i]) n_done[i]++;
        end
        if (|wdone) dut_done++;
        if (wvalid && wready && wlast) n_wlast++;
        if (wvalid) begin
            data_cyc++;
            if (first_w < 0) first_w = cyc;
        end
        if (awvalid) begin
            aw_cyc++;
            if (first_aw < 0) begin
                first_aw   = cyc;
                first_addr = awaddr;
            end
        end

        if (!arst_n) begin
            aw_pend = 0; w_act = 0; b_pend = 0; done_due = 0; m_err = 0;
            m_beats = 0; m_last = NP - 1;
            for (int i = 0; i < NP; i++) beat[i] = 0;
        end else if (done_due) begin
            done_due = 0;
        end else if (b_pend) begin
            if (bvalid) begin
                b_pend   = 0;
                done_due = 1;
                m_last   = m_ch;
                if (bresp != 2'b00) m_err = 1;
            end
        end else if (w_act) begin
            if (wready) begin
                m_beats++;
                beat[m_ch]++;
                if (m_beats == NT) begin
                    w_act  = 0;
                    b_pend = 1;
                end
            end
        end else if (aw_pend) begin
            if (awready) begin
                aw_pend = 0;
                w_act   = 1;
                m_beats = 0;
            end
        end else begin
            for (int k = 1; k <= NP; k++) begin
                if (!aw_pend && wreq[(m_last + k) % NP]) begin
                    m_ch    = (m_last + k) % NP;
                    aw_pend = 1;
                    m_addr  = {16'h0, radr[m_ch] & ~24'((1 << NB) - 1)} + {8'h0, baseadr};
                    glog.push_back(m_ch);
                end
            end
        end
    endtask

    always begin
        @(negedge aclk);
        #1;
        step();
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n = 1'b0; wreq = '0; baseadr = 32'h1000_0000;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        for (int i = 0; i < NP; i++) begin
            radr[i] = '0; seq[i] = 0; beat[i] = 0; left[i] = 0;
            n_wack[i] = 0; n_done[i] = 0; req_cyc[i] = 0;
        end
        drive();
        cycles(3);
        chk("reset outputs", 64'({awvalid, wvalid, bready, wdone, err, wack}), 64'(0));
        arst_n = 1'b1;
        cycles(2);

        // single burst, everything ready
        clr_stats();
        radr[0] = 24'h000200; left[0] = 1;
        wait_done(1, 400);
        chk("t1 awaddr", 64'(first_addr), 64'h00_1000_0200);
        chk("t1 awvalid latency", 64'(first_aw - req_cyc[0]), 64'(1));
        chk("t1 first beat latency", 64'(first_w - first_aw), 64'(1));
        chk("t1 wack0 count", 64'(n_wack[0]), 64'(64));
        chk("t1 wack1 count", 64'(n_wack[1]), 64'(0));
        chk("t1 wlast count", 64'(n_wlast), 64'(1));
        chk("t1 data cycles", 64'(data_cyc), 64'(64));
        chk("t1 wdone0 pulses", 64'(n_done[0]), 64'(1));
        chk("t1 err", 64'(err), 64'(0));

        // low address bits dropped
        clr_stats();
        radr[0] = 24'h0001FF; left[0] = 1;
        wait_done(1, 400);
        chk("t2 awaddr", 64'(first_addr), 64'h00_1000_0000);

        // both requesting from reset: strict alternation starting at 0
        arst_n = 1'b0;
        left[0] = 2; left[1] = 2;
        cycles(3);
        clr_stats();
        arst_n = 1'b1;
        wait_done(4, 1200);
        chk("t3 grant count", 64'(glog.size()), 64'(4));
        for (int k = 0; k < 4; k++)
            chk("t3 grant order", 64'((k < glog.size()) ? glog[k] : 99), 64'(k % 2));

        // wready on alternate cycles
        clr_stats();
        alt = 1; left[1] = 1;
        wait_done(1, 600);
        chk("t4 data cycles", 64'(data_cyc), 64'(127));
        chk("t4 wack1 count", 64'(n_wack[1]), 64'(64));
        alt = 0;

        // awready held low for 5 cycles
        clr_stats();
        aw_left = 5; left[0] = 1;
        wait_done(1, 400);
        chk("t5 awvalid cycles", 64'(aw_cyc), 64'(6));
        chk("t5 first beat after AW", 64'(first_w - first_aw), 64'(6));

        // SLVERR is sticky across an OKAY burst
        clr_stats();
        fixed_resp = 2'b10; left[0] = 1;
        wait_done(1, 400);
        chk("t6 err after slverr", 64'(err), 64'(1));
        chk("t6 wdone0 on slverr", 64'(n_done[0]), 64'(1));
        fixed_resp = 2'b00; left[1] = 1;
        wait_done(1, 400);
        chk("t6 err sticky", 64'(err), 64'(1));

        // reset mid-burst, then replay
        clr_stats();
        left[0] = 1;
        for (int k = 0; k < 400 && n_wack[0] < 10; k++) cycles(1);
        arst_n = 1'b0;
        cycles(1);
        chk("t7 outputs at reset edge", 64'({awvalid, wvalid, wlast, bready, wdone, err, wack}), 64'(0));
        arst_n = 1'b1;
        n_wack[0] = 0;
        wait_done(1, 400);
        chk("t7 no wdone for abandoned burst", 64'(n_done[0]), 64'(1));
        chk("t7 replay beats", 64'(n_wack[0]), 64'(64));
        chk("t7 err cleared by reset", 64'(err), 64'(0));

        // randomised traffic: stalls, B noise, mixed responses, moving addresses
        clr_stats();
        p_req = 50; p_aw = 70; p_w = 60; p_b = 50;
        noise = 1; rand_resp = 1; scramble = 1;
        left[0] = 20; left[1] = 20;
        wait_done(40, 20000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
